// File: rtl/qa_driver_csr_types_pkg.sv
// Shared types for the QA driver CSR / SREG path.
// Provides the sreg address/value types, the 512-bit response line layout
// written into host DSM, the response status enum, the data pattern reported
// when the client never answers, and a helper that forms the DSM line index.
package qa_driver_csr_types;

   typedef logic [31:0] t_sreg_addr;
   typedef logic [63:0] t_sreg;

   // Host CSR that triggers an sreg read request.
   localparam logic [15:0] CSR_AFU_SREG_READ = 16'h1a10;

   // Value reported in word 0 when the client does not respond in time.
   localparam t_sreg SREG_TIMEOUT_DATA = 64'hDEAD_DEAD_DEAD_DEAD;

   typedef enum logic {
      SREG_RSP_OK      = 1'b0,
      SREG_RSP_TIMEOUT = 1'b1
   } t_sreg_rsp_status;

   // Response line, word 7 in the MSBs down to word 0 in the LSBs.
   // Word 7 is the flag the host polls; it occupies the most significant
   // word so it lands last when the line is written out.
   typedef struct packed {
      logic [63:0]      valid_flag;   // word 7
      logic [3:0][63:0] rsvd;         // words 6..3
      logic [30:0]      rsvd_status;  // word 2 [63:33]
      logic             timeout;      // word 2 [32]
      logic [31:0]      seq;          // word 2 [31:0]
      logic [31:0]      rsvd_addr;    // word 1 [63:32]
      t_sreg_addr       addr;         // word 1 [31:0]
      t_sreg            data;         // word 0
   } t_sreg_rsp_line;

   // Cache-line index of the response line: byte base >> 6 plus line offset.
   function automatic logic [57:0] sreg_line_index(input logic [63:0] base,
                                                   input int unsigned offset);
      return base[63:6] + 58'(offset);
   endfunction

endpackage

// File: rtl/qa_driver_sreg_req_fifo.sv
// Small synchronous FIFO of pending sreg read addresses.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   push, push_data  write one entry (caller guarantees !full or pop)
//   pop              drop the head entry (caller guarantees !empty)
//   head             current head entry (show-ahead)
//   full, empty      occupancy flags
// A push while full is legal when pop is asserted in the same cycle: the
// head is read combinationally before the slot is overwritten at the edge.
module qa_driver_sreg_req_fifo
   import qa_driver_csr_types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       push,
   input  t_sreg_addr push_data,
   input  logic       pop,
   output t_sreg_addr head,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   t_sreg_addr  mem [DEPTH];
   logic [AW:0] wr_ptr_reg;
   logic [AW:0] rd_ptr_reg;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

   assign head  = mem[rd_ptr_reg[AW-1:0]];
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   // Extra pointer bit distinguishes full from empty when indices match.
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/qa_driver_sreg_rsp_writer.sv
// SREG debug-read responder.
// Queues host sreg read requests, fetches each value from the FPGA client,
// and writes one response cache line into host DSM per request.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   dsm_base_valid, dsm_base          DSM base byte address and its valid flag
//   sreg_req_en, sreg_req_addr        request pulse from CSR decode
//   req_dropped                       pulse, one cycle after a lost request
//   client_req_valid/addr/ready       request handshake to the client
//   client_rsp_valid/data             client response pulse
//   wr_valid/addr/data                c1 write request (one cycle per line)
//   wr_almost_full                    c1 back-pressure
//   wr_ack                            c1 write completion pulse
//   busy                              transaction in flight or requests queued
module qa_driver_sreg_rsp_writer
   import qa_driver_csr_types::*;
#(
   parameter int REQ_FIFO_DEPTH     = 4,
   parameter int RSP_TIMEOUT_CYCLES = 1024,
   parameter int SREG_LINE_OFFSET   = 1,
   parameter int LINE_ADDR_BITS     = 42
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      dsm_base_valid,
   input  logic [63:0]               dsm_base,
   input  logic                      sreg_req_en,
   input  logic [31:0]               sreg_req_addr,
   output logic                      req_dropped,
   output logic                      client_req_valid,
   output logic [31:0]               client_req_addr,
   input  logic                      client_req_ready,
   input  logic                      client_rsp_valid,
   input  logic [63:0]               client_rsp_data,
   output logic                      wr_valid,
   output logic [LINE_ADDR_BITS-1:0] wr_addr,
   output logic [511:0]              wr_data,
   input  logic                      wr_almost_full,
   input  logic                      wr_ack,
   output logic                      busy
);

   localparam int TIMER_W = (RSP_TIMEOUT_CYCLES > 1) ? $clog2(RSP_TIMEOUT_CYCLES) : 1;

   typedef enum logic [2:0] {
      IDLE,
      CREQ,
      WAIT_RSP,
      WRITE,
      WAIT_ACK
   } t_state;

   t_state                    state_reg;
   t_state                    state_next;
   t_sreg_addr                addr_q_reg;
   t_sreg                     data_reg;
   t_sreg_rsp_status          status_reg;
   logic [31:0]               seq_reg;
   logic [TIMER_W-1:0]        timer_reg;
   logic [LINE_ADDR_BITS-1:0] line_addr_reg;
   logic                      req_dropped_reg;

   logic                      fifo_push;
   logic                      fifo_pop;
   logic                      fifo_full;
   logic                      fifo_empty;
   t_sreg_addr                fifo_head;
   logic                      timer_expired;
   logic [LINE_ADDR_BITS-1:0] line_index;
   t_sreg_rsp_line            rsp_line;
   logic                      unused_base_bits;

   // ---------------------------------------------------------------- enqueue
   // A pop in the same cycle frees a slot, so a full queue still accepts.
   assign fifo_push = sreg_req_en && dsm_base_valid && (!fifo_full || fifo_pop);

   qa_driver_sreg_req_fifo #(
      .DEPTH (REQ_FIFO_DEPTH)
   ) u_req_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (sreg_req_addr),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_dropped_reg <= 1'b0;
      end else begin
         req_dropped_reg <= sreg_req_en && !fifo_push;
      end
   end

   assign req_dropped = req_dropped_reg;

   // ---------------------------------------------------------------- FSM
   assign timer_expired = (timer_reg == TIMER_W'(RSP_TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      fifo_pop         = 1'b0;
      client_req_valid = 1'b0;
      wr_valid         = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               state_next = CREQ;
            end
         end
         CREQ: begin
            client_req_valid = 1'b1;
            if (client_req_ready) begin
               state_next = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (client_rsp_valid || timer_expired) begin
               state_next = WRITE;
            end
         end
         WRITE: begin
            if (!wr_almost_full) begin
               wr_valid   = 1'b1;
               state_next = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (wr_ack) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- datapath
   // Line address is latched at dequeue so a later dsm_base change cannot
   // redirect a line already in flight.
   assign line_index       = LINE_ADDR_BITS'(sreg_line_index(dsm_base, SREG_LINE_OFFSET));
   assign unused_base_bits = ^dsm_base[5:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q_reg    <= '0;
         data_reg      <= '0;
         status_reg    <= SREG_RSP_OK;
         seq_reg       <= '0;
         timer_reg     <= '0;
         line_addr_reg <= '0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (!fifo_empty) begin
                  addr_q_reg    <= fifo_head;
                  line_addr_reg <= line_index;
               end
            end
            CREQ: begin
               if (client_req_ready) begin
                  timer_reg <= '0;
               end
            end
            WAIT_RSP: begin
               // A response in the expiry cycle wins over the timeout.
               if (client_rsp_valid) begin
                  data_reg   <= client_rsp_data;
                  status_reg <= SREG_RSP_OK;
               end else if (timer_expired) begin
                  data_reg   <= SREG_TIMEOUT_DATA;
                  status_reg <= SREG_RSP_TIMEOUT;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            WAIT_ACK: begin
               if (wr_ack) begin
                  seq_reg <= seq_reg + 32'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      rsp_line            = '0;
      rsp_line.valid_flag = 64'h1;
      rsp_line.timeout    = (status_reg == SREG_RSP_TIMEOUT);
      rsp_line.seq        = seq_reg;
      rsp_line.addr       = addr_q_reg;
      rsp_line.data       = data_reg;
   end

   // Payload and address are only driven while the write is presented.
   assign wr_data         = wr_valid ? rsp_line : '0;
   assign wr_addr         = wr_valid ? line_addr_reg : '0;
   assign client_req_addr = client_req_valid ? addr_q_reg : '0;
   assign busy            = (state_reg != IDLE) || !fifo_empty;

endmodule
